lane_slice_seq: RTL and testbench

LANE_SLICE_SEQ -- requirements
Module: lane_slice_seq

---
 rtl/lane_slice_if.sv | 30 +++
 rtl/lane_slice_seq.sv | 129 ++++++++++++
 tb/tb_lane_slice_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lane_slice_if.sv
// Command, issue and commit signals of the lane slice sequencer, grouped as one bundle.
// The master side offers slice commands, stall and commits; the slave side is the sequencer.
interface lane_slice_if #(
    parameter int WIDTH_INDEX = 8,
    parameter int WIDTH_LEN   = 6
);
    logic                   I_Cmd_Valid;
    logic                   O_Cmd_Ready;
    logic [WIDTH_INDEX-1:0] I_Cmd_Base;
    logic [WIDTH_INDEX-1:0] I_Cmd_Stride;
    logic [WIDTH_LEN-1:0]   I_Cmd_Len;
    logic                   I_Stall;
    logic                   O_Issue_Valid;
    logic [WIDTH_INDEX-1:0] O_Issue_Index;
    logic                   O_Issue_Last;
    logic                   I_Commit;
    logic                   O_Busy;
    logic                   O_Done;
    logic                   O_Err;

    modport master (
        output I_Cmd_Valid, I_Cmd_Base, I_Cmd_Stride, I_Cmd_Len, I_Stall, I_Commit,
        input  O_Cmd_Ready, O_Issue_Valid, O_Issue_Index, O_Issue_Last, O_Busy, O_Done, O_Err
    );

    modport slave (
        input  I_Cmd_Valid, I_Cmd_Base, I_Cmd_Stride, I_Cmd_Len, I_Stall, I_Commit,
        output O_Cmd_Ready, O_Issue_Valid, O_Issue_Index, O_Issue_Last, O_Busy, O_Done, O_Err
    );
endinterface

// File: rtl/lane_slice_seq.sv
// Lane slice sequencer: accepts a (base, stride, length) slice command, issues one
// register-file element index per cycle subject to stall and an outstanding-element
// credit limit, tracks commits and pulses O_Done once the whole slice has retired.
module lane_slice_seq #(
    parameter int WIDTH_INDEX = 8,
    parameter int WIDTH_LEN   = 6,
    parameter int MAX_OUT     = 8
) (
    input logic         clock,
    input logic         reset,
    lane_slice_if.slave bus
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0]     OUT_MAX  = OUT_W'(MAX_OUT);
    localparam logic [OUT_W-1:0]     OUT_ONE  = OUT_W'(1);
    localparam logic [OUT_W-1:0]     OUT_ZERO = '0;
    localparam logic [WIDTH_LEN-1:0] LEN_ONE  = WIDTH_LEN'(1);
    localparam logic [WIDTH_LEN-1:0] LEN_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH_INDEX-1:0] index_q, index_d;
    logic [WIDTH_INDEX-1:0] stride_q, stride_d;
    logic [WIDTH_LEN-1:0]   remain_q, remain_d;
    logic [OUT_W-1:0]       outst_q, outst_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic issue;
    logic issue_last;

    // Issue is purely a function of registered state and the live stall input.
    always_comb begin
        issue      = (state_q == ISSUE) && !bus.I_Stall && (outst_q < OUT_MAX);
        issue_last = issue && (remain_q == LEN_ONE);
    end

    // Next-state, datapath and credit-counter update.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        stride_d = stride_q;
        remain_d = remain_q;
        outst_d  = outst_q;
        done_d   = 1'b0;
        err_d    = err_q;

        // Commits are honoured in every state; an issue and a commit in the
        // same cycle cancel. A commit with nothing outstanding is an error.
        if (issue && !bus.I_Commit) begin
            outst_d = outst_q + OUT_ONE;
        end else if (bus.I_Commit && !issue) begin
            if (outst_q == OUT_ZERO) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_q - OUT_ONE;
            end
        end

        case (state_q)
            IDLE: begin
                // Acceptance follows the ready handshake alone; stall only freezes a running slice.
                if (bus.I_Cmd_Valid) begin
                    if (bus.I_Cmd_Len != LEN_ZERO) begin
                        index_d  = bus.I_Cmd_Base;
                        stride_d = bus.I_Cmd_Stride;
                        remain_d = bus.I_Cmd_Len;
                        state_d  = ISSUE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    index_d  = index_q + stride_q;
                    remain_d = remain_q - LEN_ONE;
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Retire once every element of this slice (and any earlier one) has committed.
                if (!bus.I_Stall && (outst_d == OUT_ZERO)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset; a reset abandons any slice silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            index_q  <= '0;
            stride_q <= '0;
            remain_q <= '0;
            outst_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            stride_q <= stride_d;
            remain_q <= remain_d;
            outst_q  <= outst_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.O_Cmd_Ready   = (state_q == IDLE);
    assign bus.O_Issue_Valid = issue;
    assign bus.O_Issue_Index = index_q;
    assign bus.O_Issue_Last  = issue_last;
    assign bus.O_Busy        = (state_q != IDLE);
    assign bus.O_Done        = done_q;
    assign bus.O_Err         = err_q;
endmodule

// File: tb/tb_lane_slice_seq.sv
// Bench for lane_slice_seq: directed scenarios followed by randomized traffic,
// every cycle compared against a slice-level reference model (a queue of pending
// element indices plus an outstanding count).
module tb_lane_slice_seq;
    localparam int WI      = 8;
    localparam int WL      = 6;
    localparam int MAX_OUT = 8;

    logic clk;
    logic rst;

    lane_slice_if #(.WIDTH_INDEX(WI), .WIDTH_LEN(WL)) bus ();

    lane_slice_seq #(.WIDTH_INDEX(WI), .WIDTH_LEN(WL), .MAX_OUT(MAX_OUT)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slice-level view.
    bit           m_have;      // a slice has been accepted and not yet retired
    logic [7:0]   pend[$];     // indices still to issue for the current slice
    logic [7:0]   m_nidx;      // value the index output shows
    logic [7:0]   m_stride;
    int           m_outs;
    bit           m_done;
    bit           m_err;

    // Last sampled DUT outputs.
    logic       o_ready, o_busy, o_done, o_err, o_iv, o_last;
    logic [7:0] o_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_have   = 1'b0;
        pend.delete();
        m_nidx   = 8'h00;
        m_stride = 8'h00;
        m_outs   = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic do_reset();
        bus.I_Cmd_Valid  = 1'b0;
        bus.I_Cmd_Base   = '0;
        bus.I_Cmd_Stride = '0;
        bus.I_Cmd_Len    = '0;
        bus.I_Stall      = 1'b0;
        bus.I_Commit     = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive inputs, compare outputs with the model mid-cycle, advance the model.
    task automatic step(input bit v, input logic [7:0] b, input logic [7:0] s,
                        input logic [5:0] l, input bit st, input bit cm);
        bit exp_iv;
        bit exp_last;
        bit acc;
        bit drain_now;
        bus.I_Cmd_Valid  = v;
        bus.I_Cmd_Base   = b;
        bus.I_Cmd_Stride = s;
        bus.I_Cmd_Len    = l;
        bus.I_Stall      = st;
        bus.I_Commit     = cm;
        @(negedge clk);
        o_ready = bus.O_Cmd_Ready;
        o_busy  = bus.O_Busy;
        o_done  = bus.O_Done;
        o_err   = bus.O_Err;
        o_iv    = bus.O_Issue_Valid;
        o_last  = bus.O_Issue_Last;
        o_idx   = bus.O_Issue_Index;

        exp_iv   = m_have && (pend.size() > 0) && !st && (m_outs < MAX_OUT);
        exp_last = exp_iv && (pend.size() == 1);
        chk("ready", o_ready, !m_have);
        chk("busy",  o_busy,  m_have);
        chk("done",  o_done,  m_done);
        chk("err",   o_err,   m_err);
        chk("issue_valid", o_iv, exp_iv);
        chk("issue_last",  o_last, exp_last);
        chk("issue_index", o_idx, m_nidx);

        acc       = v && !m_have;
        drain_now = m_have && (pend.size() == 0) && !st;
        if (exp_iv) begin
            void'(pend.pop_front());
            m_nidx = m_nidx + m_stride;
        end
        if (exp_iv && !cm) m_outs++;
        else if (cm && !exp_iv) begin
            if (m_outs == 0) m_err = 1'b1;
            else m_outs--;
        end
        m_done = 1'b0;
        if (drain_now && m_outs == 0) begin
            m_have = 1'b0;
            m_done = 1'b1;
        end
        if (acc) begin
            m_have = 1'b1;
            if (l != 0) begin
                m_nidx   = b;
                m_stride = s;
                for (int k = 0; k < int'(l); k++) pend.push_back(8'(int'(b) + k * int'(s)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Commit whatever is outstanding until the slice retires, with a cycle bound.
    task automatic drain(input string tag);
        for (int i = 0; i < 60 && m_have; i++) step(0, 0, 0, 0, 0, m_outs > 0);
        step(0, 0, 0, 0, 0, 0);
        chk(tag, o_ready, 1);
    endtask

    initial begin
        int n;
        model_clear();
        do_reset();

        // Reset values
        step(0, 0, 0, 0, 0, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_busy",  o_busy, 0);
        chk("rst_iv",    o_iv, 0);
        chk("rst_idx",   o_idx, 0);
        chk("rst_err",   o_err, 0);

        // Basic slice: 4,6,8 with commits two cycles after each issue
        step(1, 8'd4, 8'd2, 6'd3, 0, 0);
        step(0, 0, 0, 0, 0, 0); chk("basic_i0", {o_iv, o_idx}, {1'b1, 8'd4});
        step(0, 0, 0, 0, 0, 0); chk("basic_i1", {o_iv, o_idx}, {1'b1, 8'd6});
        step(0, 0, 0, 0, 0, 1); chk("basic_i2", {o_iv, o_last, o_idx}, {2'b11, 8'd8});
        step(0, 0, 0, 0, 0, 1); chk("basic_nodone0", o_done, 0);
        step(0, 0, 0, 0, 0, 1); chk("basic_nodone1", o_done, 0);
        step(0, 0, 0, 0, 0, 0); chk("basic_done", o_done, 1);
        step(0, 0, 0, 0, 0, 0); chk("basic_done_once", o_done, 0);

        // Wrap-around
        step(1, 8'hFE, 8'd3, 6'd3, 0, 0);
        step(0, 0, 0, 0, 0, 0); chk("wrap_i0", o_idx, 8'hFE);
        step(0, 0, 0, 0, 0, 0); chk("wrap_i1", o_idx, 8'h01);
        step(0, 0, 0, 0, 0, 0); chk("wrap_i2", {o_last, o_idx}, {1'b1, 8'h04});
        drain("wrap_drain");

        // Credit limit
        step(1, 8'd0, 8'd1, 6'd12, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0);
            n += int'(o_iv);
        end
        chk("credit_issues", n, 8);
        step(0, 0, 0, 0, 0, 1); chk("credit_blocked", o_iv, 0);
        step(0, 0, 0, 0, 0, 0); chk("credit_one_more", {o_iv, o_idx}, {1'b1, 8'd8});
        step(0, 0, 0, 0, 0, 0); chk("credit_full_again", o_iv, 0);
        drain("credit_drain");

        // Zero length: done two cycles after accept
        step(1, 8'd9, 8'd1, 6'd0, 0, 0);
        step(0, 0, 0, 0, 0, 0); chk("zero_busy", {o_busy, o_iv}, 2'b10);
        step(0, 0, 0, 0, 0, 0); chk("zero_done", o_done, 1);

        // Stall held five cycles, then two issues
        step(1, 8'd20, 8'd5, 6'd2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("stall_hold", {o_iv, o_busy, o_idx}, {2'b01, 8'd20});
        end
        step(0, 0, 0, 0, 0, 0); chk("stall_rel0", {o_iv, o_idx}, {1'b1, 8'd20});
        step(0, 0, 0, 0, 0, 0); chk("stall_rel1", {o_iv, o_idx}, {1'b1, 8'd25});
        drain("stall_drain");

        // Commit with nothing outstanding sets the sticky error
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0); chk("err_set", o_err, 1);
        step(0, 0, 0, 0, 0, 0); chk("err_sticky", o_err, 1);

        // Reset mid-slice after two of five issues
        do_reset();
        step(1, 8'd10, 8'd1, 6'd5, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 1);
        chk("midrst_state", {o_ready, o_busy, o_done, o_iv, o_last, o_err, o_idx},
            {6'b100000, 8'd0});
        step(0, 0, 0, 0, 0, 0); chk("midrst_stale_commit_err", o_err, 1);
        do_reset();
        step(1, 8'd3, 8'd1, 6'd2, 0, 0); chk("midrst_accept", o_ready, 1);
        step(0, 0, 0, 0, 0, 0); chk("midrst_new_i0", {o_iv, o_idx}, {1'b1, 8'd3});
        drain("midrst_drain");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 30,
                     8'($urandom), 8'($urandom),
                     6'($urandom_range(0, 12)),
                     $urandom_range(0, 99) < 20,
                     ($urandom_range(0, 99) < 45) && (m_outs > 0 || $urandom_range(0, 29) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
